// File: rtl/mult_v2_if.sv
// mult_v2_if: pixel-stream bundle for the mult_v2 gain stage.
//   coe_i         per-channel coefficients, channel k at [k*COE_WIDTH +: COE_WIDTH]
//   di_i          input pixel, channel k at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   de_i/hs_i/vs_i  data enable, line blanking, frame valid
//   do_o          gained pixel (valid only while de_o=1)
//   de_o/hs_o/vs_o  syncs delayed to line up with do_o
//   sat_cnt_o     saturated-pixel count of the last completed frame
//   sat_cnt_vld_o one-cycle pulse when sat_cnt_o updates
// master modport: the upstream/downstream side; slave modport: the gain stage.
interface mult_v2_if #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int CH_COUNT     = 3,
  parameter int COE_WIDTH    = 16,
  parameter int SATCNT_WIDTH = 24
);
  logic [COE_WIDTH*CH_COUNT-1:0]   coe_i;
  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i;
  logic                            de_i;
  logic                            hs_i;
  logic                            vs_i;
  logic [PIXEL_WIDTH*CH_COUNT-1:0] do_o;
  logic                            de_o;
  logic                            hs_o;
  logic                            vs_o;
  logic [SATCNT_WIDTH-1:0]         sat_cnt_o;
  logic                            sat_cnt_vld_o;

  modport master (
    output coe_i, di_i, de_i, hs_i, vs_i,
    input  do_o, de_o, hs_o, vs_o, sat_cnt_o, sat_cnt_vld_o
  );

  modport slave (
    input  coe_i, di_i, de_i, hs_i, vs_i,
    output do_o, de_o, hs_o, vs_o, sat_cnt_o, sat_cnt_vld_o
  );
endinterface

// File: rtl/mult_v2.sv
// mult_v2: per-channel pixel gain stage. Each channel is multiplied by its own
// unsigned fixed-point coefficient (COE_FRAC fractional bits), rounded half-up
// and saturated back to PIXEL_WIDTH. Fixed 3-cycle latency for data and syncs.
//   clk   pixel clock
//   rst   asynchronous reset, active low
//   bus   mult_v2_if.slave (coefficients, pixel stream in/out, saturation report)
// Coefficients are shadowed while vs_i=0 and frozen while vs_i=1, so a frame
// always sees one coefficient set.
// Build option: define MULT_V2_SATCNT_EN to include the per-frame saturation
// counter; otherwise sat_cnt_o and sat_cnt_vld_o are tied to 0.
module mult_v2 #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int CH_COUNT     = 3,
  parameter int COE_WIDTH    = 16,
  parameter int COE_FRAC     = 10,
  parameter int SATCNT_WIDTH = 24
) (
  input logic      clk,
  input logic      rst,
  mult_v2_if.slave bus
);

  localparam int PROD_W = PIXEL_WIDTH + COE_WIDTH;
  localparam int RND_W  = PROD_W + 1;  // guard bit so the rounding add cannot wrap
  localparam logic [RND_W-1:0]     HALF  = (RND_W'(1) << COE_FRAC) >> 1;
  localparam logic [COE_WIDTH-1:0] UNITY = COE_WIDTH'(1) << COE_FRAC;

  logic [CH_COUNT-1:0][COE_WIDTH-1:0]   shadow_q;
  logic [CH_COUNT-1:0][PIXEL_WIDTH-1:0] d1_q;
  logic                                 de1_q, hs1_q, vs1_q;
  logic [CH_COUNT-1:0][PROD_W-1:0]      p2_q;
  logic                                 de2_q, hs2_q, vs2_q;
  logic [CH_COUNT-1:0][RND_W-1:0]       rnd;
  logic [CH_COUNT-1:0][PIXEL_WIDTH-1:0] do_next;
  logic [CH_COUNT-1:0]                  sat_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= {CH_COUNT{UNITY}};
    end else if (!bus.vs_i) begin
      shadow_q <= bus.coe_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      p2_q  <= '0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      bus.do_o <= '0;
      bus.de_o <= 1'b0;
      bus.hs_o <= 1'b0;
      bus.vs_o <= 1'b0;
    end else begin
      d1_q  <= bus.di_i;
      de1_q <= bus.de_i;
      hs1_q <= bus.hs_i;
      vs1_q <= bus.vs_i;
      for (int k = 0; k < CH_COUNT; k++) begin
        p2_q[k] <= PROD_W'(d1_q[k]) * PROD_W'(shadow_q[k]);
      end
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      bus.do_o <= do_next;
      bus.de_o <= de2_q;
      bus.hs_o <= hs2_q;
      bus.vs_o <= vs2_q;
    end
  end

  always_comb begin
    rnd     = '0;
    sat_vec = '0;
    do_next = '0;
    for (int k = 0; k < CH_COUNT; k++) begin
      rnd[k]     = ({1'b0, p2_q[k]} + HALF) >> COE_FRAC;
      sat_vec[k] = |rnd[k][RND_W-1:PIXEL_WIDTH];
      do_next[k] = sat_vec[k] ? {PIXEL_WIDTH{1'b1}} : rnd[k][PIXEL_WIDTH-1:0];
    end
  end

`ifdef MULT_V2_SATCNT_EN
  logic [SATCNT_WIDTH-1:0] cnt_q;
  logic [SATCNT_WIDTH-1:0] cnt_inc;
  logic                    sat_any;
  logic                    vs_fall;

  assign sat_any = de2_q & (|sat_vec);
  assign cnt_inc = (sat_any && (cnt_q != {SATCNT_WIDTH{1'b1}})) ? cnt_q + SATCNT_WIDTH'(1) : cnt_q;
  // vs_o is the S3 vs register; it drops on the edge where vs2_q is already 0.
  assign vs_fall = bus.vs_o & ~vs2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q             <= '0;
      bus.sat_cnt_o     <= '0;
      bus.sat_cnt_vld_o <= 1'b0;
    end else begin
      bus.sat_cnt_vld_o <= vs_fall;
      if (vs_fall) begin
        // the pixel in the reporting cycle itself is included via cnt_inc
        bus.sat_cnt_o <= cnt_inc;
        cnt_q         <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end
`else
  assign bus.sat_cnt_o     = '0;
  assign bus.sat_cnt_vld_o = 1'b0;
`endif

endmodule
